// File: rtl/sw_input_conditioner.sv
// Per-bit switch conditioner: 2-flop synchronizer, debounce, edge pulses and sticky rise events.
// Define SW_COND_IRQ_EN to add the irq_mask input and a registered irq output.
module sw_input_conditioner #(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               CNT_W           = 20,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] evt_clear,
`ifdef SW_COND_IRQ_EN
  input  logic [WIDTH-1:0] irq_mask,
  output logic             irq,
`endif
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] event_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;
  logic [CNT_W-1:0] cnt [WIDTH];

  // A bit is accepted once it has disagreed with stable_out for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != stable_out[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign rise_next = accept & sync2;
  assign fall_next = accept & ~sync2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1      <= RESET_VAL;
      sync2      <= RESET_VAL;
      stable_out <= RESET_VAL;
      rise_pulse <= '0;
      fall_pulse <= '0;
      event_out  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1      <= raw_in;
      sync2      <= sync1;
      stable_out <= (stable_out & ~accept) | (sync2 & accept);
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      // A new rise beats a simultaneous clear so a press is never lost.
      event_out  <= (event_out & ~evt_clear) | rise_next;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable_out[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef SW_COND_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(event_out & irq_mask);
    end
  end
`endif

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Randomised and directed bench for sw_input_conditioner with DEBOUNCE_CYCLES=4.
// Expected values come from a window-based model: accept when the last D synchronized samples all disagree.
module tb_sw_input_conditioner;

  localparam int D = 4;
`ifdef SW_COND_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [7:0] raw_in;
  logic [7:0] evt_clear;
  logic [7:0] mask;
  logic [7:0] stable_out;
  logic [7:0] rise_pulse;
  logic [7:0] fall_pulse;
  logic [7:0] event_out;
  logic       irq_obs;

  int n_checks;
  int n_fail;

  logic [7:0] m_p1, m_p2, m_stable, m_rise, m_fall, m_ev;
  logic       m_irq;
  logic [7:0] m_hist[$];

  sw_input_conditioner #(
    .WIDTH(8), .DEBOUNCE_CYCLES(D), .CNT_W(20), .RESET_VAL(8'h00)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_in(raw_in),
    .evt_clear(evt_clear),
`ifdef SW_COND_IRQ_EN
    .irq_mask(mask),
    .irq(irq_obs),
`endif
    .stable_out(stable_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .event_out(event_out)
  );

`ifndef SW_COND_IRQ_EN
  assign irq_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  // Drive one edge's inputs, advance the reference model, and settle past the edge.
  task automatic cycle(input logic [7:0] r, input logic [7:0] c, input logic rn, input logic [7:0] mk);
    logic [7:0] s2;
    logic [7:0] acc;
    logic       all_diff;
    raw_in = r;
    evt_clear = c;
    reset_n = rn;
    mask = mk;
    @(posedge clk);
    if (!rn) begin
      m_p1 = 8'h00; m_p2 = 8'h00; m_stable = 8'h00;
      m_rise = 8'h00; m_fall = 8'h00; m_ev = 8'h00; m_irq = 1'b0;
      m_hist.delete();
    end else begin
      s2 = m_p2;
      m_irq = |(m_ev & mk);
      m_hist.push_back(s2);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      acc = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if (m_hist.size() == D) begin
          all_diff = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
          acc[b] = all_diff;
        end
      end
      m_rise = acc & s2;
      m_fall = acc & ~s2;
      m_ev = (m_ev & ~c) | m_rise;
      m_stable = m_stable ^ acc;
      m_p2 = m_p1;
      m_p1 = r;
    end
    #1;
  endtask

  task automatic test_reset();
    int first = -1;
    for (int e = 0; e < 3; e++) begin
      cycle(8'hFF, 8'h00, 1'b0, 8'h00);
      n_checks++;
      if ({irq_obs, stable_out, rise_pulse, fall_pulse, event_out} !== {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev}) begin
        n_fail++;
        $display("[TB] FAIL reset_hold: got %h required %h", {irq_obs, stable_out, rise_pulse, fall_pulse, event_out}, {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev});
      end
    end
    for (int e = 1; e <= 10; e++) begin
      cycle(8'hFF, 8'h00, 1'b1, 8'h00);
      n_checks++;
      if ({irq_obs, stable_out, rise_pulse, fall_pulse, event_out} !== {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev}) begin
        n_fail++;
        $display("[TB] FAIL reset_release e%0d: got %h required %h", e, {irq_obs, stable_out, rise_pulse, fall_pulse, event_out}, {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev});
      end
      if (first < 0 && stable_out == 8'hFF) first = e;
    end
    n_checks++;
    if (first !== D + 2) begin
      n_fail++;
      $display("[TB] FAIL reset_latency: got %0d edges required %0d", first, D + 2);
    end
  endtask

  task automatic test_single_bit();
    int first = -1;
    int nr = 0;
    int nf = 0;
    cycle(8'h00, 8'h00, 1'b0, 8'h00);
    for (int e = 1; e <= 16; e++) begin
      cycle((e <= 8) ? 8'h01 : 8'h00, 8'h00, 1'b1, 8'h00);
      n_checks++;
      if ({irq_obs, stable_out, rise_pulse, fall_pulse, event_out} !== {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev}) begin
        n_fail++;
        $display("[TB] FAIL single_bit e%0d: got %h required %h", e, {irq_obs, stable_out, rise_pulse, fall_pulse, event_out}, {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev});
      end
      if (first < 0 && stable_out[0]) first = e;
      if (rise_pulse[0]) nr++;
      if (fall_pulse[0]) nf++;
    end
    n_checks++;
    if ({first, nr, nf} !== {32'(D + 2), 32'd1, 32'd1} || event_out !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL single_bit_summary: got first=%0d rises=%0d falls=%0d event=%h required 6 1 1 01", first, nr, nf, event_out);
    end
  endtask

  task automatic test_glitch();
    int nr = 0;
    for (int e = 0; e < 11; e++) begin
      cycle((e < 3) ? 8'h02 : 8'h00, 8'h00, 1'b1, 8'h00);
      n_checks++;
      if ({irq_obs, stable_out, rise_pulse, fall_pulse, event_out} !== {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev}) begin
        n_fail++;
        $display("[TB] FAIL glitch e%0d: got %h required %h", e, {irq_obs, stable_out, rise_pulse, fall_pulse, event_out}, {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev});
      end
      if (rise_pulse[1]) nr++;
    end
    n_checks++;
    if ({stable_out[1], event_out[1]} !== 2'b00 || nr != 0) begin
      n_fail++;
      $display("[TB] FAIL glitch_summary: got stable1=%b event1=%b rises=%0d required 0 0 0", stable_out[1], event_out[1], nr);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pattern;
    int acc_idx = -1;
    int nr = 0;
    int nf = 0;
    pattern = 6'b101101;
    for (int i = 0; i < 16; i++) begin
      cycle((i < 6 && !pattern[5-i]) ? 8'h00 : 8'h04, 8'h00, 1'b1, 8'h00);
      n_checks++;
      if ({irq_obs, stable_out, rise_pulse, fall_pulse, event_out} !== {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev}) begin
        n_fail++;
        $display("[TB] FAIL bounce i%0d: got %h required %h", i, {irq_obs, stable_out, rise_pulse, fall_pulse, event_out}, {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev});
      end
      if (acc_idx < 0 && stable_out[2]) acc_idx = i;
      if (rise_pulse[2]) nr++;
      if (fall_pulse[2]) nf++;
    end
    n_checks++;
    if (acc_idx !== 5 + D + 1 || nr != 1 || nf != 0) begin
      n_fail++;
      $display("[TB] FAIL bounce_summary: got accept_idx=%0d rises=%0d falls=%0d required 10 1 0", acc_idx, nr, nf);
    end
  endtask

  task automatic test_evt_clear();
    logic [7:0] clr;
    for (int i = 0; i < 16; i++) begin
      clr = 8'h00;
      if (i == 2) clr = 8'h04;
      if (i == 4) clr = 8'hF0;
      if (i == 8 + D + 1) clr = 8'h04;
      cycle((i < 8) ? 8'h00 : 8'h04, clr, 1'b1, 8'h00);
      n_checks++;
      if ({irq_obs, stable_out, rise_pulse, fall_pulse, event_out} !== {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev}) begin
        n_fail++;
        $display("[TB] FAIL evt_clear i%0d: got %h required %h", i, {irq_obs, stable_out, rise_pulse, fall_pulse, event_out}, {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev});
      end
      if (i == 8 + D + 1) begin
        n_checks++;
        if ({rise_pulse[2], event_out[2]} !== 2'b11) begin
          n_fail++;
          $display("[TB] FAIL set_beats_clear: got rise2=%b event2=%b required 1 1", rise_pulse[2], event_out[2]);
        end
      end
    end
    cycle(8'h04, 8'h05, 1'b1, 8'h00);
    n_checks++;
    if (event_out !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL isolated_clear: got %h required 00", event_out);
    end
  endtask

  task automatic test_reset_midcount();
    int first = -1;
    int ev_first = -1;
    int irq_first = -1;
    for (int i = 0; i < 4; i++) cycle(8'h08, 8'h00, 1'b1, 8'h08);
    cycle(8'h08, 8'h00, 1'b0, 8'h08);
    n_checks++;
    if ({stable_out, rise_pulse, fall_pulse, event_out, irq_obs} !== 33'd0) begin
      n_fail++;
      $display("[TB] FAIL midcount_reset: got %h required 0", {stable_out, rise_pulse, fall_pulse, event_out, irq_obs});
    end
    for (int e = 1; e <= 10; e++) begin
      cycle(8'h08, 8'h00, 1'b1, 8'h08);
      n_checks++;
      if ({irq_obs, stable_out, rise_pulse, fall_pulse, event_out} !== {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev}) begin
        n_fail++;
        $display("[TB] FAIL midcount e%0d: got %h required %h", e, {irq_obs, stable_out, rise_pulse, fall_pulse, event_out}, {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev});
      end
      if (first < 0 && stable_out[3]) first = e;
      if (ev_first < 0 && event_out[3]) ev_first = e;
      if (irq_first < 0 && irq_obs) irq_first = e;
    end
    n_checks++;
    if (first !== D + 2) begin
      n_fail++;
      $display("[TB] FAIL midcount_latency: got %0d edges required %0d", first, D + 2);
    end
`ifdef SW_COND_IRQ_EN
    n_checks++;
    if (irq_first !== ev_first + 1) begin
      n_fail++;
      $display("[TB] FAIL irq_latency: got edge %0d required %0d", irq_first, ev_first + 1);
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [7:0] c;
    logic [7:0] mk;
    logic       rn;
    r = 8'h00;
    mk = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      c = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      rn = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 31) == 0) mk = 8'($urandom);
      cycle(r, c, rn, mk);
      n_checks++;
      if ({irq_obs, stable_out, rise_pulse, fall_pulse, event_out} !== {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev}) begin
        n_fail++;
        $display("[TB] FAIL random i%0d: got %h required %h", i, {irq_obs, stable_out, rise_pulse, fall_pulse, event_out}, {m_irq & IRQ_EN, m_stable, m_rise, m_fall, m_ev});
      end
      n_checks++;
      if ((rise_pulse & fall_pulse) !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL random_excl i%0d: got rise&fall=%h required 00", i, rise_pulse & fall_pulse);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    reset_n = 1'b0;
    raw_in = 8'h00;
    evt_clear = 8'h00;
    mask = 8'h00;
    n_checks = 0;
    n_fail = 0;
    m_p1 = 8'h00; m_p2 = 8'h00; m_stable = 8'h00;
    m_rise = 8'h00; m_fall = 8'h00; m_ev = 8'h00; m_irq = 1'b0;
    test_reset();
    test_single_bit();
    test_glitch();
    test_bounce();
    test_evt_clear();
    test_reset_midcount();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
